// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select width, compare/min/max opcodes
// and the default datapath width used by the compare pipeline.
package alu_pkg;

    localparam int OPW       = 3;
    localparam int DEF_WIDTH = 64;

    typedef enum logic [OPW-1:0] {
        OP_SLT  = 3'b000,   // signed A < B
        OP_SLTU = 3'b001,   // unsigned A < B
        OP_SEQ  = 3'b010,   // A == B
        OP_SNE  = 3'b011,   // A != B
        OP_SGE  = 3'b100,   // signed A >= B
        OP_SGEU = 3'b101,   // unsigned A >= B
        OP_MIN  = 3'b110,   // signed minimum
        OP_MAX  = 3'b111    // signed maximum
    } op_e;

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand/result bus of the compare pipeline.
//
// Handshake: each direction is a valid/ready pair. A beat transfers on a
// rising clock edge where valid and ready are both 1. A source that raises
// valid keeps valid and its payload unchanged until that transfer; ready
// may depend combinationally on the consumer's ready (in_ready follows
// out_ready within the same cycle).
interface cmp_pipe_if #(parameter int WIDTH = alu_pkg::DEF_WIDTH);

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         A;
    logic [WIDTH-1:0]         B;
    logic [alu_pkg::OPW-1:0]  Op;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         Result;
    logic                     Ovf;

    // Operand dispatch / writeback side
    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, Result, Ovf
    );

    // Compare unit side
    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, Result, Ovf
    );

endinterface

// File: rtl/cmp_sub.sv
// Combinational subtract-based comparator: one A + ~B + 1 adder yields the
// difference, borrow, signed overflow and the signed/unsigned less-than
// flags. Shared with the branch unit.
module cmp_sub #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_d,
    output logic             o_borrow,
    output logic             o_ovf,
    output logic             o_lt_s,
    output logic             o_lt_u,
    output logic             o_eq
);

    logic [WIDTH:0] w_sum;

    // Extra top bit carries out of the subtraction; carry=1 means no borrow.
    assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign o_d      = w_sum[WIDTH-1:0];
    assign o_borrow = ~w_sum[WIDTH];

    // Overflow only possible when operand signs differ and the result sign
    // disagrees with A; then the raw sign bit of D lies, so flip it.
    assign o_ovf  = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) & (w_sum[WIDTH-1] ^ i_a[WIDTH-1]);
    assign o_lt_s = w_sum[WIDTH-1] ^ o_ovf;
    assign o_lt_u = o_borrow;
    assign o_eq   = (i_a == i_b);

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage compare unit for the ALU result path. Stage 1 captures the
// operands; stage 2 runs the subtract-based compare and registers Result
// and Ovf, so the adder sits alone between two register banks.
module cmp_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    cmp_pipe_if.slave   bus
);

    // Stage 1 (operand) registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;

    // Stage 2 (result) registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    // Pipeline control and compare results
    logic             w_s2_en;
    logic             w_s1_en;
    logic [WIDTH-1:0] w_d;
    logic             w_borrow;
    logic             w_ovf;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_eq;
    logic [WIDTH-1:0] w_result;

    // A stage may load when it is empty or its content moves on this edge.
    // in_ready therefore follows out_ready combinationally.
    assign w_s2_en = ~r_out_valid | bus.out_ready;
    assign w_s1_en = ~r_s1_valid | w_s2_en;

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_out_valid;
    assign bus.Result    = r_result;
    assign bus.Ovf       = r_ovf;

    cmp_sub #(.WIDTH(WIDTH)) u_cmp_sub (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_d      (w_d),
        .o_borrow (w_borrow),
        .o_ovf    (w_ovf),
        .o_lt_s   (w_lt_s),
        .o_lt_u   (w_lt_u),
        .o_eq     (w_eq)
    );

    // Select the result for the staged op; flag ops return 0/1 zero-extended.
    always_comb begin
        w_result = '0;
        case (r_s1_op)
            OP_SLT:  w_result[0] = w_lt_s;
            OP_SLTU: w_result[0] = w_lt_u;
            OP_SEQ:  w_result[0] = w_eq;
            OP_SNE:  w_result[0] = |w_d;
            OP_SGE:  w_result[0] = ~w_lt_s;
            OP_SGEU: w_result[0] = ~w_borrow;
            OP_MIN:  w_result    = w_lt_s ? r_s1_a : r_s1_b;
            OP_MAX:  w_result    = w_lt_s ? r_s1_b : r_s1_a;
            default: w_result    = '0;
        endcase
    end

    // Stage 1 occupancy: refills (or empties into a bubble) whenever it may advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
        end
    end

    // Stage 1 payload: captured only on an accepted operation.
    always_ff @(posedge clk) begin
        if (w_s1_en && bus.in_valid) begin
            r_s1_a  <= bus.A;
            r_s1_b  <= bus.B;
            r_s1_op <= op_e'(bus.Op);
        end
    end

    // Stage 2: register the compare result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Testbench for cmp_pipe: directed corner cases, back-to-back and
// backpressure sequences, mid-flight reset, then randomized traffic checked
// against an arithmetic reference model through an expected-result queue.
module tb_cmp_pipe;
    import alu_pkg::*;

    localparam int W = DEF_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_pipe_if #(.WIDTH(W)) bus ();

    cmp_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];      // {Ovf, Result} per accepted op, in order
    int         acc_cyc_q[$];
    int         out_cyc_q[$];

    task automatic check_v(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ovf=%0b res=%h, expected ovf=%0b res=%h",
                     name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from the mathematical meaning of each op: signed/unsigned
    // comparisons of the operand values, and overflow as "the exact signed
    // difference does not fit in W bits".
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] op);
        logic signed [W:0] diff;
        logic              ovf;
        logic [W-1:0]      r;
        diff = $signed({a[W-1], a}) - $signed({b[W-1], b});
        ovf  = (diff[W] != diff[W-1]);
        r    = '0;
        case (op)
            OP_SLT:  r[0] = ($signed(a) <  $signed(b));
            OP_SLTU: r[0] = (a < b);
            OP_SEQ:  r[0] = (a == b);
            OP_SNE:  r[0] = (a != b);
            OP_SGE:  r[0] = ($signed(a) >= $signed(b));
            OP_SGEU: r[0] = (a >= b);
            OP_MIN:  r    = ($signed(a) < $signed(b)) ? a : b;
            default: r    = ($signed(a) > $signed(b)) ? a : b;
        endcase
        return {ovf, r};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    // Samples 1 time unit before each rising edge, where handshake values
    // that the edge will act on are settled.
    logic       prev_stall = 1'b0;
    logic [W:0] prev_out   = '0;
    logic [W:0] exp_e;

    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_i("hold_valid", int'(bus.out_valid), 1);
                check_v("hold_result", {bus.Ovf, bus.Result}, prev_out);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out: result %h delivered with no outstanding op", bus.Result);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_v("result", {bus.Ovf, bus.Result}, exp_e);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.Op));
                acc_cyc_q.push_back(cyc);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.Ovf, bus.Result};
        end
    end

    // ---------------- driver tasks (call at a falling edge) ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        bus.A        = a;
        bus.B        = b;
        bus.Op       = op;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            #4;
            if (bus.in_ready) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OPW-1:0] op, input logic [W:0] exp);
        bus.out_ready = 1'b1;
        send(a, b, op);
        #4;
        check_i({name, "_not_early"}, int'(bus.out_valid), 0);
        @(negedge clk);
        #4;
        check_i({name, "_valid"}, int'(bus.out_valid), 1);
        check_v(name, {bus.Ovf, bus.Result}, exp);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge clk);
        check_i(name, exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {W{1'b1}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [W:0]     exp8[8];
    logic [W-1:0]   bp_a[3];
    logic [W-1:0]   bp_b[3];
    logic [OPW-1:0] bp_op[3];
    int             bp_rdy[4];
    int             n_acc;
    logic           acc;
    bit             rand_done;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Op        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        check_i("rst_out_valid", int'(bus.out_valid), 0);
        check_v("rst_result", {bus.Ovf, bus.Result}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check_i("in_ready_after_rst", int'(bus.in_ready), 1);
        @(negedge clk);

        // Pin the model with hand-computed values
        check_v("model_slt_ovf",  model(64'h8000_0000_0000_0000, 64'd1, OP_SLT), {1'b1, 64'd1});
        check_v("model_slt_max",  model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SLT),  {1'b1, 64'd0});
        check_v("model_sltu_max", model(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SLTU), {1'b1, 64'd1});
        check_v("model_min_neg",  model(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, OP_MIN), {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        check_v("model_max_neg",  model(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, OP_MAX), {1'b0, 64'd3});
        exp8[0] = {1'b0, 64'd0}; exp8[1] = {1'b0, 64'd0}; exp8[2] = {1'b0, 64'd1}; exp8[3] = {1'b0, 64'd0};
        exp8[4] = {1'b0, 64'd1}; exp8[5] = {1'b0, 64'd1}; exp8[6] = {1'b0, 64'd5}; exp8[7] = {1'b0, 64'd5};
        for (int i = 0; i < 8; i++) check_v($sformatf("model_eq5_op%0d", i), model(64'd5, 64'd5, 3'(i)), exp8[i]);

        // Directed corner cases through the DUT with literal expectations
        run_one("slt_ovf",  64'h8000_0000_0000_0000, 64'd1, OP_SLT, {1'b1, 64'd1});
        run_one("slt_max",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SLT,  {1'b1, 64'd0});
        run_one("sltu_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SLTU, {1'b1, 64'd1});
        run_one("min_neg",  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, OP_MIN, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_one("max_neg",  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, OP_MAX, {1'b0, 64'd3});

        // Back-to-back: all ops on A=B=5, one per cycle
        acc_cyc_q.delete();
        out_cyc_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(64'd5, 64'd5, 3'(i));
        repeat (4) @(negedge clk);
        check_i("b2b_accepts", acc_cyc_q.size(), 8);
        check_i("b2b_outputs", out_cyc_q.size(), 8);
        if (acc_cyc_q.size() == 8 && out_cyc_q.size() == 8) begin
            check_i("b2b_latency",     out_cyc_q[0] - acc_cyc_q[0], 2);
            check_i("b2b_in_rate",     acc_cyc_q[7] - acc_cyc_q[0], 7);
            check_i("b2b_out_rate",    out_cyc_q[7] - out_cyc_q[0], 7);
        end
        drain("b2b_drain");

        // Backpressure: out_ready low for 4 cycles while 3 ops are offered
        bp_a[0] = 64'd10;                  bp_b[0] = 64'd20;                  bp_op[0] = OP_SLT;
        bp_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; bp_b[1] = 64'd1;                   bp_op[1] = OP_SLTU;
        bp_a[2] = 64'h8000_0000_0000_0000; bp_b[2] = 64'h7FFF_FFFF_FFFF_FFFF; bp_op[2] = OP_MAX;
        bus.out_ready = 1'b0;
        n_acc         = 0;
        bus.A = bp_a[0]; bus.B = bp_b[0]; bus.Op = bp_op[0]; bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #4;
            bp_rdy[c] = int'(bus.in_ready);
            acc       = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) begin
                n_acc++;
                bus.A = bp_a[n_acc]; bus.B = bp_b[n_acc]; bus.Op = bp_op[n_acc];
            end
        end
        check_i("bp_rdy_c0", bp_rdy[0], 1);
        check_i("bp_rdy_c1", bp_rdy[1], 1);
        check_i("bp_rdy_c2", bp_rdy[2], 0);
        check_i("bp_rdy_c3", bp_rdy[3], 0);
        check_i("bp_accepts_stalled", n_acc, 2);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10 && n_acc < 3; t++) begin
            #4;
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) n_acc++;
        end
        bus.in_valid = 1'b0;
        check_i("bp_accepts_total", n_acc, 3);
        drain("bp_drain");

        // Reset while a MAX is in flight
        bus.out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, OP_MAX);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check_i("midrst_out_valid", int'(bus.out_valid), 0);
        check_v("midrst_result", {bus.Ovf, bus.Result}, '0);
        @(negedge clk);
        #4;
        check_i("midrst_no_stale", int'(bus.out_valid), 0);
        repeat (4) @(negedge clk);

        // Randomized traffic with random gaps and random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    ra = rand_opnd();
                    rb = ($urandom_range(0, 3) == 0) ? ra : rand_opnd();
                    send(ra, rb, OPW'($urandom_range(0, 7)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
